ram512_fill_engine: RTL and testbench

//  Upstream write/verify sequencer for RAM512. It owns the RAM512 port (address/in/load) and can block-fill a

---
 rtl/ram512_fill_engine.sv | 167 ++++++++++++++++
 tb/tb_ram512_fill_engine.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram512_fill_engine.sv
// ram512_fill_engine: write/verify sequencer that owns the RAM512 port.
// While idle, the host port is passed straight through to the RAM. On start, the
// engine block-fills a wrap-around address range with either a constant or an
// incrementing pattern. It can then read the range back and flag the first mismatch.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start                      operation request, sampled only in IDLE
//   base, count                first address and word count (0..512) of the range
//   pattern, incr, check       fill value, increment mode, read-back compare enable
//   host_address/in/load       host RAM port, forwarded when not busy
//   ram_address/in/load        RAM512 write/address port (decoded from state)
//   ram_out                    RAM512 combinational read data
//   busy, done                 operation in progress, one-cycle completion pulse
//   error, err_address         sticky compare failure and first failing address
module ram512_fill_engine #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [AW:0]      count,
    input  logic [WIDTH-1:0] pattern,
    input  logic             incr,
    input  logic             check,
    input  logic [AW-1:0]    host_address,
    input  logic [WIDTH-1:0] host_in,
    input  logic             host_load,
    output logic [AW-1:0]    ram_address,
    output logic [WIDTH-1:0] ram_in,
    output logic             ram_load,
    input  logic [WIDTH-1:0] ram_out,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [AW-1:0]    err_address
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [AW:0]        idx;
    logic [AW-1:0]      base_q;
    logic [AW:0]        count_q;
    logic [WIDTH-1:0]   pattern_q;
    logic               incr_q;
    logic               check_q;

    logic [AW:0]        idx_next;
    logic               last;
    logic [AW-1:0]      cur_address;
    logic [WIDTH-1:0]   cur_word;

    // Current range address and data word. The AW-bit sum wraps modulo the RAM depth.
    assign idx_next    = idx + (AW+1)'(1);
    assign last        = (idx_next == count_q);
    assign cur_address = base_q + idx[AW-1:0];
    assign cur_word    = incr_q ? WIDTH'(pattern_q + WIDTH'(idx)) : pattern_q;

    // Drive the RAM port from the engine while busy; pass the host port through otherwise.
    always_comb begin
        ram_address = host_address;
        ram_in      = host_in;
        ram_load    = host_load;
        unique case (state)
            FILL: begin
                ram_address = cur_address;
                ram_in      = cur_word;
                ram_load    = 1'b1;
            end
            CHECK: begin
                ram_address = cur_address;
                ram_in      = cur_word;
                ram_load    = 1'b0;
            end
            DONE: begin
                ram_address = base_q;
                ram_in      = '0;
                ram_load    = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Sequencer: the state, index, latched parameters and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            base_q      <= '0;
            count_q     <= '0;
            pattern_q   <= '0;
            incr_q      <= 1'b0;
            check_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q      <= base;
                        count_q     <= count;
                        pattern_q   <= pattern;
                        incr_q      <= incr;
                        check_q     <= check;
                        idx         <= '0;
                        error       <= 1'b0;
                        err_address <= '0;
                        busy        <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (last) begin
                        idx <= '0;
                        if (check_q) begin
                            state <= CHECK;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        idx <= idx_next;
                    end
                end
                CHECK: begin
                    // Only the first mismatch is recorded; error stays sticky.
                    if ((ram_out != cur_word) && !error) begin
                        error       <= 1'b1;
                        err_address <= cur_address;
                    end
                    if (last) begin
                        idx   <= '0;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram512_fill_engine.sv
// Testbench for ram512_fill_engine. It models RAM512 behaviourally, drives a table of
// directed operations followed by random operations, and compares the results against a
// range-level reference model. It also includes hand sequences for host passthrough,
// ignored host writes and start requests while busy, and reset during a fill.
module tb_ram512_fill_engine;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 512;
    localparam logic [15:0] XORV  = 16'h0F0F;

    typedef struct {
        logic [8:0]  base;
        logic [9:0]  count;
        logic [15:0] pattern;
        logic        incr;
        logic        check;
        logic [7:0]  mask;      // words 0..7 of the range to corrupt during CHECK
        int          exp_done;  // cycle in which done is high (start edge = 0)
        logic        exp_err;
        logic [8:0]  exp_eaddr;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  base;
    logic [9:0]  count;
    logic [15:0] pattern;
    logic        incr;
    logic        check;
    logic [8:0]  host_address;
    logic [15:0] host_in;
    logic        host_load;
    logic [8:0]  ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  err_address;

    logic [15:0] mem     [DEPTH];
    logic [15:0] ref_mem [DEPTH];
    logic        corr_en;
    logic [8:0]  corr_addr;
    logic [15:0] corr_val;

    vec_t tbl [6];
    int   total;
    int   bad;

    ram512_fill_engine #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .pattern(pattern), .incr(incr), .check(check),
        .host_address(host_address), .host_in(host_in), .host_load(host_load),
        .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load),
        .ram_out(ram_out), .busy(busy), .done(done), .error(error),
        .err_address(err_address)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM512 model with a side port that lets the bench corrupt a word.
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
        if (corr_en)  mem[corr_addr]   <= corr_val;
    end
    assign ram_out = mem[ram_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input vec_t v, input int j);
        return v.incr ? 16'(v.pattern + 16'(j)) : v.pattern;
    endfunction

    function automatic logic [8:0] addr_of(input vec_t v, input int j);
        return 9'(v.base + 9'(j));
    endfunction

    function automatic bit corrupted(input vec_t v, input int j);
        return v.check && (j < 8) && (j < int'(v.count)) && v.mask[3'(j)];
    endfunction

    // Reference timing and error result, derived from the operation parameters.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        int   n = int'(v.count);
        r.exp_done  = (n == 0) ? 1 : (v.check ? 2 * n + 1 : n + 1);
        r.exp_err   = 1'b0;
        r.exp_eaddr = '0;
        for (int j = 0; j < 8; j++) begin
            if (corrupted(v, j) && !r.exp_err) begin
                r.exp_err   = 1'b1;
                r.exp_eaddr = addr_of(v, j);
            end
        end
        return r;
    endfunction

    task automatic apply_model(input vec_t v);
        for (int j = 0; j < int'(v.count); j++) begin
            logic [15:0] w = word_of(v, j);
            if (corrupted(v, j)) w = w ^ XORV;
            ref_mem[addr_of(v, j)] = w;
        end
    endtask

    task automatic mem_check(input string name);
        int nbad  = 0;
        int first = -1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem[i] !== ref_mem[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        if (nbad != 0) $display("  %s: first differing word at %0d", name, first);
        chk(name, 32'(nbad), 0);
    endtask

    // Run one operation. A nonzero poke cycle injects a host write and a new start there.
    task automatic run_op(input vec_t v, input int poke);
        int  dones = 0, loads = 0, busys = 0, done_cyc = -1;
        bit  finished = 0;
        int  bound = 2 * int'(v.count) + 10;
        @(negedge clk);
        base = v.base; count = v.count; pattern = v.pattern;
        incr = v.incr; check = v.check; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            start   = 1'b0;
            host_load = 1'b0;
            corr_en = 1'b0;
            if (c == poke) begin
                host_address = 9'd300; host_in = 16'h1234; host_load = 1'b1;
                start = 1'b1; base = 9'd0; count = 10'd3;
            end
            if (v.check && c >= int'(v.count) && c < 2 * int'(v.count)
                && corrupted(v, c - int'(v.count))) begin
                corr_en   = 1'b1;
                corr_addr = addr_of(v, c - int'(v.count));
                corr_val  = word_of(v, c - int'(v.count)) ^ XORV;
            end
            #1;
            if (c == poke) begin
                chk("poke_load", 32'(ram_load), 1);
                chk("poke_addr", 32'(ram_address), 32'(addr_of(v, c - 1)));
                chk("poke_data", 32'(ram_in), 32'(word_of(v, c - 1)));
            end
            if (busy) busys++;
            if (ram_load) loads++;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
                chk("done_addr", 32'(ram_address), 32'(v.base));
            end
            if (dones > 0 && !busy) begin
                finished = 1;
                break;
            end
        end
        corr_en = 1'b0;
        chk("op_complete", 32'(finished), 1);
        chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
        chk("done_pulses", 32'(dones), 1);
        chk("busy_cycles", 32'(busys), 32'(v.exp_done));
        chk("load_cycles", 32'(loads), 32'(v.count));
        chk("error", 32'(error), 32'(v.exp_err));
        chk("err_address", 32'(err_address), 32'(v.exp_eaddr));
        apply_model(v);
        mem_check("mem");
    endtask

    initial begin
        total = 0; bad = 0;
        start = 0; base = '0; count = '0; pattern = '0; incr = 0; check = 0;
        corr_en = 0; corr_addr = '0; corr_val = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

        //            base     count    pattern   incr  chk   mask   done  err   eaddr
        tbl[0] = '{9'd0,   10'd512, 16'h0000, 1'b0, 1'b1, 8'h00, 1025, 1'b0, 9'd0};
        tbl[1] = '{9'd510, 10'd4,   16'hFFFE, 1'b1, 1'b0, 8'h00, 5,    1'b0, 9'd0};
        tbl[2] = '{9'd7,   10'd0,   16'h1234, 1'b0, 1'b1, 8'h01, 1,    1'b0, 9'd0};
        tbl[3] = '{9'd40,  10'd8,   16'hA5A5, 1'b0, 1'b1, 8'h48, 17,   1'b1, 9'd43};
        tbl[4] = '{9'd508, 10'd8,   16'h0100, 1'b1, 1'b1, 8'h01, 17,   1'b1, 9'd508};
        tbl[5] = '{9'd511, 10'd1,   16'hBEEF, 1'b0, 1'b1, 8'h01, 3,    1'b1, 9'd511};

        // Reset state, with the host port passed through during reset.
        reset = 1'b1;
        host_address = 9'd9; host_in = 16'h0077; host_load = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_eaddr", 32'(err_address), 0);
        chk("rst_pass_load", 32'(ram_load), 1);
        chk("rst_pass_addr", 32'(ram_address), 9);
        host_load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_op(tbl[k], 0);
            if (k == 1) begin
                chk("wrap_510", 32'(mem[510]), 32'hFFFE);
                chk("wrap_511", 32'(mem[511]), 32'hFFFF);
                chk("wrap_0",   32'(mem[0]),   32'h0000);
                chk("wrap_1",   32'(mem[1]),   32'h0001);
            end
        end
        chk("error_sticky_idle", 32'(error), 1);

        // Reset clears the error status.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst2_error", 32'(error), 0);
        chk("rst2_eaddr", 32'(err_address), 0);
        @(negedge clk);
        reset = 1'b0;

        // Reset after three fill writes aborts the operation at once.
        begin
            vec_t v = '{9'd200, 10'd16, 16'h7000, 1'b1, 1'b0, 8'h00, 17, 1'b0, 9'd0};
            int   late_done = 0;
            @(negedge clk);
            base = v.base; count = v.count; pattern = v.pattern;
            incr = v.incr; check = v.check; start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("abort_pre_load", 32'(ram_load), 1);
            reset = 1'b1;
            #1;
            chk("abort_busy", 32'(busy), 0);
            chk("abort_load", 32'(ram_load), 0);
            @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (done || busy) late_done++;
            end
            chk("abort_no_done", 32'(late_done), 0);
            for (int j = 0; j < 3; j++) ref_mem[addr_of(v, j)] = word_of(v, j);
            mem_check("abort_mem");
        end

        // Host write while idle lands in RAM.
        @(negedge clk);
        host_address = 9'd5; host_in = 16'hBEEF; host_load = 1'b1;
        #1;
        chk("host_addr", 32'(ram_address), 5);
        chk("host_data", 32'(ram_in), 32'hBEEF);
        chk("host_load", 32'(ram_load), 1);
        @(negedge clk);
        host_load = 1'b0;
        ref_mem[5] = 16'hBEEF;
        chk("host_mem", 32'(mem[5]), 32'hBEEF);

        // Host write and new start during FILL are both ignored.
        begin
            vec_t v = '{9'd100, 10'd8, 16'h0010, 1'b1, 1'b0, 8'h00, 9, 1'b0, 9'd0};
            run_op(v, 3);
            chk("poke_mem300", 32'(mem[300]), 32'(ref_mem[300]));
        end

        // Random operations checked against the reference model.
        for (int k = 0; k < 24; k++) begin
            vec_t v;
            v.base    = 9'($urandom_range(0, 511));
            v.count   = (k % 8 == 0) ? 10'($urandom_range(0, 512)) : 10'($urandom_range(0, 20));
            v.pattern = 16'($urandom);
            v.incr    = 1'($urandom);
            v.check   = 1'($urandom);
            v.mask    = ((k % 3) == 0) ? 8'($urandom) : 8'h00;
            v = predict(v);
            run_op(v, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
